// File: rtl/frame_pkg.sv
// Shared definitions for the frame transmit path.
//   - SOF/EOF framing byte constants used by the frame generator side.
//   - Scheduler state encoding (also exported on the debug state output).
//   - Default timing constants for the scheduler parameters.
package frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hFB;
  localparam logic [7:0] EOF_BYTE = 8'hFD;

  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_START_TO = 4;
  localparam int DEF_FRAME_TO = 64;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_WAIT_VALID = 3'd2,
    ST_BUSY       = 3'd3,
    ST_GAP        = 3'd4
  } sched_state_e;

endpackage

// File: rtl/frame_tx_scheduler_if.sv
// Bundle of all non-clock/reset signals of frame_tx_scheduler.
//   master : the scheduler (drives grant/done/gen_*/status/debug)
//   slave  : requesters + generator + configuration (drives req/gen_valid/inj_*)
//
// Handshake semantics:
//   req[i] is a level request; the requester holds it until it sees done[i].
//   grant is one-hot for the frame owner; done is a one-cycle pulse to that owner.
//   gen_start is a one-cycle pulse; the generator answers by raising gen_valid for
//   the length of the frame, and its falling edge marks the end of the frame.
interface frame_tx_scheduler_if
  import frame_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  localparam int SW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] done;
  logic               gen_start;
  logic               gen_valid;
  logic [SW-1:0]      gen_sel;
  logic               gen_error_injection;
  logic [7:0]         gen_error_position;
  logic [7:0]         inj_period;
  logic [7:0]         inj_position;
  logic               err_timeout;
  logic [15:0]        frame_count;
  sched_state_e       dbg_state;

  modport master (
    input  req, gen_valid, inj_period, inj_position,
    output grant, done, gen_start, gen_sel, gen_error_injection,
           gen_error_position, err_timeout, frame_count, dbg_state
  );

  modport slave (
    output req, gen_valid, inj_period, inj_position,
    input  grant, done, gen_start, gen_sel, gen_error_injection,
           gen_error_position, err_timeout, frame_count, dbg_state
  );
endinterface

// File: rtl/frame_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req : request vector
//   ptr : index with highest priority this round
//   gnt : one-hot grant of the first set bit at or after ptr (wrapping)
//   idx : binary index of gnt
//   any : at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Round-robin frame scheduler in front of a single frame generator.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : frame_tx_scheduler_if.master (requests, generator control,
//           error-injection control, timeout/frame-count status, debug state)
// Each frame: arbitrate in IDLE, pulse gen_start, wait for gen_valid, follow the
// valid window to its falling edge, pulse done to the owner, then idle GAP_CYC
// cycles. Start and frame-length timeouts abort a frame and set a sticky flag.
module frame_tx_scheduler
  import frame_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int START_TO = DEF_START_TO,
  parameter int FRAME_TO = DEF_FRAME_TO
) (
  input  logic                 clk,
  input  logic                 reset,
  frame_tx_scheduler_if.master bus
);

  localparam int SW = $clog2(NUM_REQ);
  // Timers count from 0, so the terminal value is one less than the limit.
  localparam logic [15:0] START_LAST = 16'(START_TO - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_TO - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(NUM_REQ - 1);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               gen_start_q, gen_start_d;
  logic [SW-1:0]      gen_sel_q, gen_sel_d;
  logic               inj_q, inj_d;
  logic [7:0]         pos_q, pos_d;
  logic               err_q, err_d;
  logic [15:0]        fc_q, fc_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [7:0]         inj_cnt_q, inj_cnt_d;
  logic [15:0]        timer_q, timer_d;
  logic [7:0]         gap_q, gap_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [SW-1:0]      pick_idx;
  logic               pick_any;
  logic [SW-1:0]      ptr_next;

  rr_arbiter #(.N(NUM_REQ), .IW(SW)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next round starts just after the current owner.
  assign ptr_next = (gen_sel_q == LAST_IDX) ? '0 : gen_sel_q + SW'(1);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    done_d      = '0;
    gen_start_d = 1'b0;
    gen_sel_d   = gen_sel_q;
    inj_d       = inj_q;
    pos_d       = pos_q;
    err_d       = err_q;
    fc_d        = fc_q;
    ptr_d       = ptr_q;
    inj_cnt_d   = inj_cnt_q;
    timer_d     = timer_q;
    gap_d       = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d   = pick_gnt;
          gen_sel_d = pick_idx;
          pos_d     = bus.inj_position;
          if ((bus.inj_period != 8'd0) && ((inj_cnt_q + 8'd1) == bus.inj_period)) begin
            inj_d     = 1'b1;
            inj_cnt_d = 8'd0;
          end else begin
            inj_d     = 1'b0;
            inj_cnt_d = inj_cnt_q + 8'd1;
          end
          state_d = ST_START;
        end
      end

      ST_START: begin
        gen_start_d = 1'b1;
        timer_d     = '0;
        state_d     = ST_WAIT_VALID;
      end

      ST_WAIT_VALID: begin
        if (bus.gen_valid) begin
          timer_d = '0;
          state_d = ST_BUSY;
        end else if (timer_q == START_LAST) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          inj_d   = 1'b0;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_BUSY: begin
        // Valid checked before the timer: a window of exactly FRAME_TO cycles is legal.
        if (!bus.gen_valid) begin
          done_d  = grant_q;
          fc_d    = fc_q + 16'd1;
          grant_d = '0;
          inj_d   = 1'b0;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (timer_q == FRAME_LAST) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          grant_d = '0;
          inj_d   = 1'b0;
          ptr_d   = ptr_next;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      gen_start_q <= 1'b0;
      gen_sel_q   <= '0;
      inj_q       <= 1'b0;
      pos_q       <= '0;
      err_q       <= 1'b0;
      fc_q        <= '0;
      ptr_q       <= '0;
      inj_cnt_q   <= '0;
      timer_q     <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      gen_start_q <= gen_start_d;
      gen_sel_q   <= gen_sel_d;
      inj_q       <= inj_d;
      pos_q       <= pos_d;
      err_q       <= err_d;
      fc_q        <= fc_d;
      ptr_q       <= ptr_d;
      inj_cnt_q   <= inj_cnt_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
    end
  end

  assign bus.grant               = grant_q;
  assign bus.done                = done_q;
  assign bus.gen_start           = gen_start_q;
  assign bus.gen_sel             = gen_sel_q;
  assign bus.gen_error_injection = inj_q;
  assign bus.gen_error_position  = pos_q;
  assign bus.err_timeout         = err_q;
  assign bus.frame_count         = fc_q;
  assign bus.dbg_state           = state_q;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Bench for frame_tx_scheduler: a behavioural generator answers gen_start with a
// programmable delay/length valid window; a frame-level reference model predicts
// owner, injection, done timing, frame count and timeout flag for each frame.
module tb_frame_tx_scheduler;
  import frame_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int GAP_CYC  = 4;
  localparam int START_TO = 4;
  localparam int FRAME_TO = 64;

  logic clk;
  logic reset;
  frame_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  frame_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .GAP_CYC(GAP_CYC), .START_TO(START_TO), .FRAME_TO(FRAME_TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- generator model ----------------
  // Cycle 0 is the cycle gen_start is high; valid is high in cycles gen_delay .. gen_delay+gen_len-1.
  int gen_delay = 1;
  int gen_len   = 1;
  int gcyc      = -1;
  initial begin
    bus.gen_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset)             gcyc = -1;
      else if (bus.gen_start) gcyc = 0;
      else if (gcyc >= 0)     gcyc++;
      bus.gen_valid = (gcyc >= 0) && (gcyc >= gen_delay) && (gcyc < gen_delay + gen_len);
    end
  end

  // ---------------- reference model state ----------------
  int          total = 0;
  int          bad   = 0;
  int          m_ptr = 0;
  logic [7:0]  m_cnt = 8'd0;
  logic [15:0] m_fc  = 16'd0;
  logic        m_err = 1'b0;
  bit          have_last = 1'b0;
  int          last_done = 0;
  bit          obs_inj;

  function automatic int model_pick(input logic [NUM_REQ-1:0] rq);
    for (int k = 0; k < NUM_REQ; k++)
      if (rq[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    return 0;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 8'd0; m_fc = 16'd0; m_err = 1'b0; have_last = 1'b0;
  endtask

  // One complete frame: request, grant, start pulse, valid window, done, model update.
  task automatic do_frame(input logic [NUM_REQ-1:0] rq, input int d, input int l,
                          input bit keep, input bit drop);
    int owner, n, exp_off, t_grant, bad_hold;
    bit exp_inj, tmo_start, tmo_frame;
    logic [7:0] exp_pos;
    logic [NUM_REQ-1:0] exp_gnt;
    bus.req   = rq;
    gen_delay = d;
    gen_len   = l;
    owner     = model_pick(rq);
    exp_gnt   = NUM_REQ'(1 << owner);
    exp_pos   = bus.inj_position;
    exp_inj   = (bus.inj_period != 8'd0) && (8'(m_cnt + 8'd1) == bus.inj_period);
    m_cnt     = exp_inj ? 8'd0 : 8'(m_cnt + 8'd1);
    tmo_start = (d > START_TO - 1);
    tmo_frame = !tmo_start && (l > FRAME_TO);
    exp_off   = tmo_start ? START_TO : (tmo_frame ? d + FRAME_TO + 1 : d + l + 1);

    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant == '0 && n < 40);
    total++;
    if (bus.grant == '0) begin
      bad++; $display("FAIL grant_wait got=none exp=%b", exp_gnt);
      bus.req = '0;
      return;
    end
    t_grant = cyc;
    if (have_last) begin
      total++;
      if (t_grant - last_done !== GAP_CYC + 1) begin
        bad++; $display("FAIL gap_len got=%0d exp=%0d", t_grant - last_done, GAP_CYC + 1);
      end
    end
    total++;
    if (bus.grant !== exp_gnt) begin bad++; $display("FAIL grant got=%b exp=%b", bus.grant, exp_gnt); end
    total++;
    if (bus.gen_sel !== 2'(owner)) begin bad++; $display("FAIL gen_sel got=%0d exp=%0d", bus.gen_sel, owner); end
    total++;
    if (bus.gen_start !== 1'b0) begin bad++; $display("FAIL start_early got=%b exp=0", bus.gen_start); end
    total++;
    if (bus.gen_error_injection !== exp_inj) begin
      bad++; $display("FAIL inj got=%b exp=%b", bus.gen_error_injection, exp_inj);
    end
    obs_inj = bus.gen_error_injection;
    if (exp_inj) begin
      total++;
      if (bus.gen_error_position !== exp_pos) begin
        bad++; $display("FAIL inj_pos got=%0d exp=%0d", bus.gen_error_position, exp_pos);
      end
    end

    @(negedge clk);
    total++;
    if (bus.gen_start !== 1'b1) begin bad++; $display("FAIL start_pulse got=%b exp=1", bus.gen_start); end
    if (drop) bus.req = '0;

    n = 0; bad_hold = 0;
    do begin
      @(negedge clk); n++;
      if (bus.done == '0) begin
        if (bus.gen_start || bus.grant !== exp_gnt || bus.gen_error_injection !== exp_inj ||
            (exp_inj && bus.gen_error_position !== exp_pos)) bad_hold++;
      end
    end while (bus.done == '0 && n < 300);
    last_done = cyc;
    total++;
    if (bad_hold !== 0) begin bad++; $display("FAIL frame_hold got=%0d bad cycles exp=0", bad_hold); end
    total++;
    if (n !== exp_off) begin bad++; $display("FAIL done_time got=%0d exp=%0d", n, exp_off); end
    total++;
    if (bus.done !== exp_gnt) begin bad++; $display("FAIL done got=%b exp=%b", bus.done, exp_gnt); end
    total++;
    if (bus.grant !== '0 || bus.gen_error_injection !== 1'b0) begin
      bad++; $display("FAIL gap_clear got grant=%b inj=%b exp=0", bus.grant, bus.gen_error_injection);
    end
    m_ptr = (owner + 1) % NUM_REQ;
    if (tmo_start || tmo_frame) m_err = 1'b1;
    else m_fc = 16'(m_fc + 16'd1);
    total++;
    if (bus.frame_count !== m_fc) begin bad++; $display("FAIL frame_count got=%0d exp=%0d", bus.frame_count, m_fc); end
    total++;
    if (bus.err_timeout !== m_err) begin bad++; $display("FAIL err_timeout got=%b exp=%b", bus.err_timeout, m_err); end
    if (!keep && !drop) bus.req = rq & ~exp_gnt;
    have_last = 1'b1;

    @(negedge clk);
    total++;
    if (bus.done !== '0) begin bad++; $display("FAIL done_width got=%b exp=0", bus.done); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    total++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.gen_start !== 1'b0 || bus.gen_sel !== '0 ||
        bus.gen_error_injection !== 1'b0 || bus.gen_error_position !== 8'd0 ||
        bus.err_timeout !== 1'b0 || bus.frame_count !== 16'd0 || bus.dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_vals got grant=%b done=%b start=%b sel=%0d inj=%b fc=%0d err=%b exp all 0",
                      bus.grant, bus.done, bus.gen_start, bus.gen_sel, bus.gen_error_injection,
                      bus.frame_count, bus.err_timeout);
    end
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus.grant !== '0 || bus.gen_start !== 1'b0) begin
      bad++; $display("FAIL idle_noreq got grant=%b start=%b exp 0", bus.grant, bus.gen_start);
    end
  endtask

  task automatic test_single();
    do_frame(4'b0001, 2, 18, 1'b0, 1'b0);
  endtask

  task automatic test_fairness();
    for (int i = 0; i < 5; i++) do_frame(4'b1111, 1 + (i % 3), 3 + i, 1'b1, 1'b0);
    bus.req = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_frame(4'b0001, 1, 5, 1'b0, 1'b0);
    bus.inj_position = 8'hA5;
    bus.req   = 4'b0100;
    gen_delay = 1;
    gen_len   = 1000;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.grant == '0 && n < 40);
    repeat (8) @(negedge clk);
    total++;
    if (bus.dbg_state !== ST_BUSY) begin bad++; $display("FAIL pre_reset_state got=%0d exp=%0d", bus.dbg_state, ST_BUSY); end
    reset   = 1'b0;
    bus.req = '0;
    #1;
    total++;
    if (bus.grant !== '0 || bus.done !== '0 || bus.gen_start !== 1'b0 || bus.gen_sel !== '0 ||
        bus.gen_error_injection !== 1'b0 || bus.gen_error_position !== 8'd0 ||
        bus.frame_count !== 16'd0 || bus.dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL async_reset got grant=%b sel=%0d pos=%0d fc=%0d state=%0d exp all 0",
                      bus.grant, bus.gen_sel, bus.gen_error_position, bus.frame_count, bus.dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    bus.inj_position = 8'd0;
    n = 0;
    repeat (6) begin @(negedge clk); if (bus.gen_start) n++; end
    total++;
    if (n !== 0) begin bad++; $display("FAIL start_after_reset got=%0d exp=0", n); end
    do_frame(4'b1111, 2, 6, 1'b0, 1'b0);
  endtask

  task automatic test_injection();
    int cnt;
    bus.inj_period   = 8'd3;
    bus.inj_position = 8'd5;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      do_frame(NUM_REQ'($urandom_range(1, 15)), 1, 4, 1'b0, 1'b0);
      if (obs_inj) cnt++;
    end
    total++;
    if (cnt !== 2) begin bad++; $display("FAIL inj_count_p3 got=%0d exp=2", cnt); end
    bus.inj_period = 8'd0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      do_frame(NUM_REQ'($urandom_range(1, 15)), 2, 3, 1'b0, 1'b0);
      if (obs_inj) cnt++;
    end
    total++;
    if (cnt !== 0) begin bad++; $display("FAIL inj_count_p0 got=%0d exp=0", cnt); end
  endtask

  task automatic test_start_timeout();
    do_frame(4'b0011, 1000, 1, 1'b1, 1'b0);   // generator never answers
    do_frame(4'b0011, 3, 7, 1'b0, 1'b0);      // latest legal valid rise, next requester
  endtask

  task automatic test_frame_timeout();
    do_frame(4'b1000, 1, FRAME_TO, 1'b0, 1'b0);      // longest legal window
    do_frame(4'b1000, 1, FRAME_TO + 1, 1'b0, 1'b0);  // one cycle too long
    do_frame(4'b1000, 2, 1000, 1'b0, 1'b0);          // valid stuck high
    do_frame(4'b0110, 1, 2, 1'b0, 1'b1);             // back to normal, req dropped mid-frame
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      bus.inj_period   = 8'($urandom_range(0, 4));
      bus.inj_position = 8'($urandom_range(0, 255));
      do_frame(NUM_REQ'($urandom_range(1, 15)), $urandom_range(1, 3), $urandom_range(1, 30),
               1'b0, ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    reset            = 1'b0;
    bus.req          = '0;
    bus.inj_period   = 8'd0;
    bus.inj_position = 8'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_fairness();
    test_reset_mid();
    test_injection();
    test_start_timeout();
    test_frame_timeout();
    test_random();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_tx_scheduler.md
Name: frame_tx_scheduler

Overview:
Shares one frame generator between NUM_REQ requesters using round-robin arbitration. Sequences each frame with a one-cycle start pulse, then tracks the generator's valid window to detect frame completion. Schedules periodic single-bit error injection for link test and guards every frame with timeouts. Sits between the requester FIFOs and the generator; gen_sel steers the generator's 16-byte payload mux.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
GAP_CYC, 4, idle cycles between frames (1..255)
START_TO, 4, max cycles from gen_start to gen_valid rising
FRAME_TO, 64, max cycles gen_valid may stay high

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester frame request, level; held until matching done bit
grant  out  NUM_REQ  one-hot owner of the current frame
done  out  NUM_REQ  one-cycle pulse to owner at frame end (normal or timeout)
gen_start  out  1  one-cycle start pulse to generator
gen_valid  in  1  generator valid
gen_sel  out  clog2(NUM_REQ)  index of granted requester
gen_error_injection  out  1  error enable to generator, held for whole frame
gen_error_position  out  8  bit position to flip, held for whole frame
inj_period  in  8  inject on every inj_period-th frame; 0 = never
inj_position  in  8  bit position, sampled at grant
err_timeout  out  1  sticky; set on any timeout, cleared by reset only
frame_count  out  16  frames completed, wraps at 0xFFFF->0

Behaviour:
- Reset (reset low, async): state IDLE; grant, done, gen_start, gen_error_injection, err_timeout = 0; gen_sel, gen_error_position, frame_count = 0; RR pointer = 0; injection counter = 0.
- States: IDLE, START, WAIT_VALID, BUSY, GAP.
- IDLE: if any req bit is high, grant the first set bit at or after the RR pointer (wrapping); next cycle START. Latch gen_sel, grant, and injection decision/position in the same edge. No req: stay.
- Injection decision: inj_cnt increments per granted frame; if inj_period != 0 and inj_cnt+1 == inj_period, inject and clear inj_cnt. inj_period changing mid-frame takes effect at the next grant.
- START: gen_start = 1 for exactly one cycle; go to WAIT_VALID with timer cleared.
- WAIT_VALID: gen_valid high -> BUSY. Timer reaching START_TO -> set err_timeout, pulse done, go to GAP.
- BUSY: gen_valid falling (sampled low) -> pulse done[owner], frame_count+1, go to GAP. Timer reaching FRAME_TO -> err_timeout, pulse done, no frame_count increment, go to GAP.
- GAP: grant = 0, gen_error_injection = 0; hold GAP_CYC cycles, then IDLE. RR pointer = owner+1 mod NUM_REQ, updated on exit from BUSY/WAIT_VALID.
- Latency: req high in IDLE -> grant next edge -> gen_start one cycle later.
- req dropped mid-frame: ignored; frame completes; done still pulses.
- New req arriving mid-frame: waits for IDLE. Owner's req still high after done: it re-arbitrates but yields to others via pointer.
- done and grant are never asserted for more than one requester simultaneously.
- Reset mid-frame: immediate return to reset values; generator is not sent a further start.

Decomposition:
- Shared package frame_pkg: SOF/EOF byte constants, state enum for the scheduler, default timeout constants.
- Sub-module rr_arbiter (combinational one-hot pick from req vector and pointer), reused by future multi-port blocks.

Test Plan:
- Single requester: req=4'b0001; model generator gives valid high 18 cycles -> grant=0001, gen_start pulse 1 cycle after grant, done[0] pulse after valid falls, frame_count=1, then 4 GAP cycles.
- Fairness: req=4'b1111 held -> owners 0,1,2,3,0 in order; each done matches grant.
- Injection: inj_period=3, inj_position=5, 6 frames -> gen_error_injection high with position 5 on frames 3 and 6 only; inj_period=0 -> never.
- Start timeout: generator never asserts valid -> err_timeout=1 after 4 cycles in WAIT_VALID, done pulses, frame_count unchanged, next requester served.
- Frame timeout: valid stuck high -> err_timeout set at 64 cycles, done pulses, scheduler returns to IDLE after GAP.
- Reset mid-BUSY: reset low for 1 cycle -> all outputs 0 immediately, next req served starting from requester 0.
